// File: rtl/pipeline_mem.sv
// ---------------------------------------------------------------------------
// pipeline_mem : RV32I memory-access stage, serial byte-wide RAM port
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_mem #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        rd_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        mre_i,
  input  logic              mrsign_i,
  input  logic [1:0]        mwe_i,
  input  logic [31:0]       mwdata_i,
  input  logic [ADDR_W-1:0] ma_i,
  input  logic [4:0]        stall_i,
  output logic              stall_req_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  output logic [4:0]        rd_o,
  output logic              we_o,
  output logic [31:0]       wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_n;
  logic [ADDR_W-1:0]  r_base;
  logic [1:0]         r_size;
  logic               r_sign;
  logic               r_load;
  logic [31:0]        r_sdata;
  logic [31:0]        r_rdata;
  logic [4:0]         r_rd;
  logic               r_we;

  logic               w_req;
  logic               w_accept;
  logic               w_capture;
  logic [2:0]         w_n;
  logic               w_issue;
  logic [7:0]         w_sbyte;
  logic [31:0]        w_ld_val;
  logic [4:0]         w_rd_n;
  logic               w_we_n;
  logic [31:0]        w_wdata_n;
  logic               w_unused;

  // Only the MEM and WB stall bits concern this stage.
  assign w_unused = ^stall_i[2:0];

  assign w_req = (mre_i != 2'd0) || (mwe_i != 2'd0);

  always_comb begin
    case (r_size)
      2'd1:    w_n = 3'd1;
      2'd2:    w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

  always_comb begin
    case (r_cnt[1:0])
      2'd0:    w_sbyte = r_sdata[7:0];
      2'd1:    w_sbyte = r_sdata[15:8];
      2'd2:    w_sbyte = r_sdata[23:16];
      default: w_sbyte = r_sdata[31:24];
    endcase
  end

  always_comb begin
    case (r_size)
      2'd1:    w_ld_val = {{24{r_sign & r_rdata[7]}},  r_rdata[7:0]};
      2'd2:    w_ld_val = {{16{r_sign & r_rdata[15]}}, r_rdata[15:0]};
      default: w_ld_val = r_rdata;
    endcase
  end

  // READ keeps running one cycle past the last address to catch the final byte.
  assign w_issue     = ((r_state == S_READ) && (r_cnt < w_n)) || (r_state == S_WRITE);
  assign mem_a_o     = w_issue ? (r_base + ADDR_W'(r_cnt)) : '0;
  assign mem_dout_o  = (r_state == S_WRITE) ? w_sbyte : 8'h00;
  assign mem_wr_o    = (r_state == S_WRITE) && rdy;
  assign stall_req_o = ((r_state == S_IDLE) && w_req) || (r_state == S_READ) ||
                       (r_state == S_WRITE);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_rd_n    = 5'd0;
    w_we_n    = 1'b0;
    w_wdata_n = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_n   = 3'd0;
          w_state_n = (mre_i != 2'd0) ? S_READ : S_WRITE;
        end else if (!stall_i[3]) begin
          w_rd_n    = rd_i;
          w_we_n    = we_i;
          w_wdata_n = wdata_i;
        end
      end
      S_READ: begin
        w_capture = (r_cnt != 3'd0);
        w_cnt_n   = r_cnt + 3'd1;
        if (r_cnt == w_n) begin
          w_state_n = S_DONE;
        end
      end
      S_WRITE: begin
        w_cnt_n = r_cnt + 3'd1;
        if (r_cnt == (w_n - 3'd1)) begin
          w_state_n = S_DONE;
        end
      end
      default: begin
        if (r_load) begin
          w_rd_n    = r_rd;
          w_we_n    = r_we;
          w_wdata_n = w_ld_val;
        end
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_base  <= '0;
      r_size  <= 2'd0;
      r_sign  <= 1'b0;
      r_load  <= 1'b0;
      r_sdata <= 32'd0;
      r_rdata <= 32'd0;
      r_rd    <= 5'd0;
      r_we    <= 1'b0;
      rd_o    <= 5'd0;
      we_o    <= 1'b0;
      wdata_o <= 32'd0;
    end else if (rdy) begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_base  <= ma_i;
        r_load  <= (mre_i != 2'd0);
        r_size  <= (mre_i != 2'd0) ? mre_i : mwe_i;
        r_sign  <= mrsign_i;
        r_sdata <= mwdata_i;
        r_rdata <= 32'd0;
        r_rd    <= rd_i;
        r_we    <= we_i;
      end
      // RAM data lags its address by one cycle, so byte k lands when cnt is k+1.
      if (w_capture) begin
        case (r_cnt)
          3'd1:    r_rdata[7:0]   <= mem_din_i;
          3'd2:    r_rdata[15:8]  <= mem_din_i;
          3'd3:    r_rdata[23:16] <= mem_din_i;
          3'd4:    r_rdata[31:24] <= mem_din_i;
          default: ;
        endcase
      end
      if (!stall_i[4]) begin
        rd_o    <= w_rd_n;
        we_o    <= w_we_n;
        wdata_o <= w_wdata_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_mem.sv
// Directed bench for pipeline_mem with a one-cycle-latency byte RAM model.
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [4:0]  rd_i = 5'd0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic [1:0]  mre_i = 2'd0;
  logic        mrsign_i = 1'b0;
  logic [1:0]  mwe_i = 2'd0;
  logic [31:0] mwdata_i = 32'd0;
  logic [31:0] ma_i = 32'd0;
  logic [4:0]  stall_i = 5'd0;
  logic        stall_req_o;
  logic [7:0]  mem_din_i = 8'h00;
  logic [7:0]  mem_dout_o;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [4:0]  rd_o;
  logic        we_o;
  logic [31:0] wdata_o;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];
  logic [31:0] a_log [$];

  pipeline_mem #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rd_i(rd_i), .we_i(we_i), .wdata_i(wdata_i),
    .mre_i(mre_i), .mrsign_i(mrsign_i), .mwe_i(mwe_i), .mwdata_i(mwdata_i), .ma_i(ma_i),
    .stall_i(stall_i), .stall_req_o(stall_req_o),
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
    .rd_o(rd_o), .we_o(we_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  // The shared RAM port is frozen by the global ready just like the pipeline.
  always @(posedge clk) begin
    if (rdy) mem_din_i <= ram.exists(mem_a_o) ? ram[mem_a_o] : 8'h00;
    if (mem_wr_o) begin
      ram[mem_a_o] = mem_dout_o;
      wr_a.push_back(mem_a_o);
      wr_d.push_back(mem_dout_o);
    end
  end

  // Presents one memory instruction until the stage stops stalling, then
  // retires it; returns the number of stalled cycles. rdy drops for three
  // cycles starting on stalled cycle frz (frz < 0: never).
  task automatic issue(input logic [1:0] re, input logic [1:0] wsz, input logic sg,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] sd,
                       input int frz, output int ncyc);
    @(negedge clk);
    mre_i = re; mwe_i = wsz; mrsign_i = sg; rd_i = rd; we_i = (re != 2'd0);
    wdata_i = a; ma_i = a; mwdata_i = sd;
    a_log.delete(); wr_a.delete(); wr_d.delete();
    ncyc = 0;
    #1;
    while (stall_req_o === 1'b1 && ncyc < 40) begin
      a_log.push_back(mem_a_o);
      ncyc++;
      if (ncyc == frz) rdy = 1'b0;
      if (ncyc == frz + 3) rdy = 1'b1;
      @(negedge clk); #1;
    end
    rdy = 1'b1;
    if (ncyc >= 40) begin
      nvec++; nerr++;
      $display("FAIL issue_timeout: stall_req_o still %b after %0d cycles, required 0", stall_req_o, ncyc);
    end
    mre_i = 2'd0; mwe_i = 2'd0; we_i = 1'b0; rd_i = 5'd0; wdata_i = 32'd0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    nvec++; if (rd_o !== 5'd0 || we_o !== 1'b0 || wdata_o !== 32'd0) begin
      nerr++; $display("FAIL reset_out: got rd=%0d we=%b wdata=%h, required 0/0/0", rd_o, we_o, wdata_o); end
    nvec++; if (stall_req_o !== 1'b0 || mem_wr_o !== 1'b0 || mem_a_o !== 32'd0 || mem_dout_o !== 8'd0) begin
      nerr++; $display("FAIL reset_mem: got stall=%b wr=%b a=%h dout=%h, required all 0",
                       stall_req_o, mem_wr_o, mem_a_o, mem_dout_o); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    rd_i = 5'd5; we_i = 1'b1; wdata_i = 32'h1234;
    #1;
    nvec++; if (stall_req_o !== 1'b0) begin
      nerr++; $display("FAIL alu_stall: got %b, required 0", stall_req_o); end
    @(negedge clk); #1;
    nvec++; if (rd_o !== 5'd5 || we_o !== 1'b1 || wdata_o !== 32'h1234 || stall_req_o !== 1'b0) begin
      nerr++; $display("FAIL alu_pass: got rd=%0d we=%b wdata=%h stall=%b, required 5/1/00001234/0",
                       rd_o, we_o, wdata_o, stall_req_o); end
  endtask

  task automatic test_stall_bits();
    @(negedge clk);
    stall_i = 5'b10000; rd_i = 5'd7; we_i = 1'b1; wdata_i = 32'h55;
    @(negedge clk); #1;
    nvec++; if (rd_o !== 5'd5 || we_o !== 1'b1 || wdata_o !== 32'h1234) begin
      nerr++; $display("FAIL wb_hold: got rd=%0d we=%b wdata=%h, required 5/1/00001234", rd_o, we_o, wdata_o); end
    stall_i = 5'b01000;
    @(negedge clk); #1;
    nvec++; if (rd_o !== 5'd0 || we_o !== 1'b0 || wdata_o !== 32'd0) begin
      nerr++; $display("FAIL mem_bubble: got rd=%0d we=%b wdata=%h, required 0/0/0", rd_o, we_o, wdata_o); end
    stall_i = 5'b00000; rd_i = 5'd0; we_i = 1'b0; wdata_i = 32'd0;
  endtask

  task automatic test_lw();
    int n;
    issue(2'd3, 2'd0, 1'b0, 5'd9, 32'h100, 32'd0, -1, n);
    nvec++; if (n !== 6) begin nerr++; $display("FAIL lw_stall_cycles: got %0d, required 6", n); end
    for (int k = 0; k < 4; k++) begin
      nvec++; if (a_log[k+1] !== 32'h100 + k) begin
        nerr++; $display("FAIL lw_addr%0d: got %h, required %h", k, a_log[k+1], 32'h100 + k); end
    end
    nvec++; if (wdata_o !== 32'h12345678 || we_o !== 1'b1 || rd_o !== 5'd9) begin
      nerr++; $display("FAIL lw_result: got wdata=%h we=%b rd=%0d, required 12345678/1/9", wdata_o, we_o, rd_o); end
  endtask

  task automatic test_lb_lh();
    int n;
    issue(2'd1, 2'd0, 1'b1, 5'd3, 32'h20, 32'd0, -1, n);
    nvec++; if (wdata_o !== 32'hFFFFFF80 || n !== 3) begin
      nerr++; $display("FAIL lb_signed: got %h in %0d cycles, required ffffff80 in 3", wdata_o, n); end
    issue(2'd2, 2'd0, 1'b0, 5'd4, 32'h21, 32'd0, -1, n);
    nvec++; if (wdata_o !== 32'h0000FFFE || n !== 4) begin
      nerr++; $display("FAIL lhu: got %h in %0d cycles, required 0000fffe in 4", wdata_o, n); end
    issue(2'd2, 2'd0, 1'b1, 5'd4, 32'h21, 32'd0, -1, n);
    nvec++; if (wdata_o !== 32'hFFFFFFFE) begin
      nerr++; $display("FAIL lh_signed: got %h, required fffffffe", wdata_o); end
  endtask

  task automatic test_sw();
    int n;
    logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    issue(2'd0, 2'd3, 1'b0, 5'd0, 32'h40, 32'hDEADBEEF, -1, n);
    nvec++; if (n !== 5 || wr_a.size() !== 4) begin
      nerr++; $display("FAIL sw_cycles: got stall=%0d writes=%0d, required 5/4", n, wr_a.size()); end
    for (int k = 0; k < 4; k++) begin
      nvec++; if (wr_a[k] !== 32'h40 + k || wr_d[k] !== eb[k]) begin
        nerr++; $display("FAIL sw_byte%0d: got %h@%h, required %h@%h", k, wr_d[k], wr_a[k], eb[k], 32'h40 + k); end
    end
    nvec++; if (we_o !== 1'b0 || rd_o !== 5'd0 || mem_wr_o !== 1'b0) begin
      nerr++; $display("FAIL sw_after: got we=%b rd=%0d wr=%b, required 0/0/0", we_o, rd_o, mem_wr_o); end
  endtask

  task automatic test_sh_wrap();
    int n;
    issue(2'd0, 2'd2, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h1234A5C3, -1, n);
    nvec++; if (wr_a.size() !== 2 || wr_a[0] !== 32'hFFFFFFFF || wr_a[1] !== 32'h0 ||
                wr_d[0] !== 8'hC3 || wr_d[1] !== 8'hA5) begin
      nerr++; $display("FAIL sh_wrap: got %0d writes %h@%h %h@%h, required c3@ffffffff a5@00000000",
                       wr_a.size(), wr_d[0], wr_a[0], wr_d[1], wr_a[1]); end
    issue(2'd2, 2'd0, 1'b0, 5'd6, 32'hFFFFFFFF, 32'd0, -1, n);
    nvec++; if (wdata_o !== 32'h0000A5C3 || n !== 4) begin
      nerr++; $display("FAIL lhu_wrap: got %h in %0d cycles, required 0000a5c3 in 4", wdata_o, n); end
  endtask

  task automatic test_rdy_freeze();
    int n;
    logic [31:0] ea [9] = '{32'h0, 32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103, 32'h0};
    issue(2'd3, 2'd0, 1'b0, 5'd11, 32'h100, 32'd0, 3, n);
    nvec++; if (n !== 9) begin nerr++; $display("FAIL rdy_cycles: got %0d, required 9", n); end
    for (int k = 1; k < 9; k++) begin
      nvec++; if (a_log[k] !== ea[k]) begin
        nerr++; $display("FAIL rdy_addr%0d: got %h, required %h", k, a_log[k], ea[k]); end
    end
    nvec++; if (wdata_o !== 32'h12345678 || we_o !== 1'b1 || rd_o !== 5'd11) begin
      nerr++; $display("FAIL rdy_result: got wdata=%h we=%b rd=%0d, required 12345678/1/11", wdata_o, we_o, rd_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    mre_i = 2'd3; rd_i = 5'd12; we_i = 1'b1; ma_i = 32'h100; wdata_i = 32'h100;
    @(negedge clk);
    @(negedge clk); #1;
    nvec++; if (mem_a_o !== 32'h101 || stall_req_o !== 1'b1) begin
      nerr++; $display("FAIL rmid_pre: got a=%h stall=%b, required 00000101/1", mem_a_o, stall_req_o); end
    rst = 1'b1; mre_i = 2'd0; rd_i = 5'd0; we_i = 1'b0; wdata_i = 32'd0;
    @(negedge clk); #1;
    nvec++; if (stall_req_o !== 1'b0 || rd_o !== 5'd0 || we_o !== 1'b0 || wdata_o !== 32'd0 ||
                mem_wr_o !== 1'b0 || mem_a_o !== 32'd0) begin
      nerr++; $display("FAIL rmid_reset: got stall=%b rd=%0d we=%b wdata=%h wr=%b a=%h, required all 0",
                       stall_req_o, rd_o, we_o, wdata_o, mem_wr_o, mem_a_o); end
    rst = 1'b0;
    issue(2'd3, 2'd0, 1'b0, 5'd13, 32'h100, 32'd0, -1, n);
    nvec++; if (wdata_o !== 32'h12345678 || rd_o !== 5'd13 || n !== 6) begin
      nerr++; $display("FAIL rmid_after: got wdata=%h rd=%0d in %0d cycles, required 12345678/13 in 6",
                       wdata_o, rd_o, n); end
  endtask

  initial begin
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h20]  = 8'h80; ram[32'h21]  = 8'hFE; ram[32'h22]  = 8'hFF;
    test_reset();
    test_alu();
    test_stall_bits();
    test_lw();
    test_lb_lh();
    test_sw();
    test_sh_wrap();
    test_rdy_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_mem.md
Name: pipeline_mem

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between EX and WB.
- Consumes the EX/MEM bundle: destination register, write enable, ALU result, load/store size, sign flag, store data and address.
- Performs loads and stores over the byte-wide, one-cycle-latency shared RAM port, assembling or splitting bytes serially.
- Stalls upstream stages while an access is in flight, then presents the registered MEM/WB bundle, which EX also uses for forwarding.

Parameters:
- ADDR_W, 32, width of the memory address bus and ma_i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- rd_i  in  5  destination register from EX.
- we_i  in  1  register write enable from EX.
- wdata_i  in  32  ALU result from EX.
- mre_i  in  2  load size: 0 none, 1 byte, 2 half, 3 word.
- mrsign_i  in  1  load sign-extend.
- mwe_i  in  2  store size, same encoding as mre_i.
- mwdata_i  in  32  store data.
- ma_i  in  ADDR_W  access base address.
- stall_i  in  5  pipeline stall vector; bit3 = MEM stalled, bit4 = WB stalled.
- stall_req_o  out  1  MEM requests pipeline stall.
- mem_din_i  in  8  RAM read byte, valid the cycle after its address.
- mem_dout_o  out  8  RAM write byte.
- mem_a_o  out  ADDR_W  RAM byte address.
- mem_wr_o  out  1  RAM write strobe.
- rd_o  out  5  destination register to WB and EX forwarding.
- we_o  out  1  write enable to WB and EX forwarding.
- wdata_o  out  32  writeback data to WB and EX forwarding.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, cnt 0, all latches 0; rd_o 0, we_o 0, wdata_o 0.
- Memory-side outputs are combinational from state only: mem_a_o 0, mem_dout_o 0, mem_wr_o 0 whenever not issuing.
- Request: req = (mre_i != 0) or (mwe_i != 0). N = 1, 2 or 4 bytes for size codes 1, 2, 3.
- stall_req_o = (state==IDLE and req) or state==READ or state==WRITE. It is 0 in DONE.
- rdy=0: no state, counter or output register changes; mem_wr_o forced 0.
- stall_i[4]=1: rd_o, we_o and wdata_o hold; the FSM may still advance.
- Byte ordering: all transfers little-endian, byte k at base+k.
- Address arithmetic: base+k computed modulo 2^ADDR_W, wraps silently. Misaligned addresses are legal.

State machine:
- IDLE, no req, stall_i[3]=0: pass through; rd_o<=rd_i, we_o<=we_i, wdata_o<=wdata_i.
- IDLE, no req, stall_i[3]=1: bubble; we_o<=0, rd_o<=0, wdata_o<=0.
- IDLE, req: latch base, size, sign, store data, rd_i and we_i; cnt<=0.
  - Go to READ if mre_i!=0, else WRITE. Load takes priority if both are set.
  - Output registers take a bubble.
- READ:
  - While cnt<N, drive mem_a_o=base+cnt.
  - When cnt>=1, capture mem_din_i into byte cnt-1.
  - cnt increments each cycle; after the cnt==N cycle (last capture), go to DONE.
  - Output registers take a bubble.
- WRITE:
  - Drive mem_a_o=base+cnt, mem_dout_o=store byte cnt, mem_wr_o=1.
  - After cnt==N-1, go to DONE.
  - Output registers take a bubble.
- DONE:
  - Load: rd_o<=latched rd, we_o<=latched we, wdata_o<=assembled value. Byte/half is sign- or zero-extended per the latched sign flag.
  - Store: we_o<=0, rd_o<=0, wdata_o<=0.
  - Go to IDLE. Upstream advances on this same edge, so the held request is not relaunched.

Latency:
- Load of N bytes, accepted in IDLE at cycle T: READ occupies T+1..T+N+1, DONE is T+N+2, result registered at the end of T+N+2.
- Store of N bytes: WRITE occupies T+1..T+N, DONE is T+N+1.

Reset mid-operation:
- Abandons the access immediately.
- Any bytes already written stay written.
- Returns to IDLE with the reset values above.

Test Plan:
- ALU op (rd 5, we 1, wdata 0x1234, mre/mwe 0) -> next cycle rd_o 5, we_o 1, wdata_o 0x1234; stall_req_o never high.
- LW at 0x100 with RAM bytes 0x78,0x56,0x34,0x12 -> mem_a_o 0x100..0x103 in consecutive cycles; stall_req_o high 6 cycles; wdata_o 0x12345678 with we_o 1.
- LB at 0x20, byte 0x80, sign=1 -> wdata_o 0xFFFFFF80. LHU at 0x21, bytes 0xFE,0xFF -> 0x0000FFFE.
- SW 0xDEADBEEF at 0x40 -> mem_wr_o high 4 cycles; addresses 0x40..0x43 carry 0xEF,0xBE,0xAD,0xDE; we_o 0 afterwards.
- SH at 0xFFFFFFFF -> writes to 0xFFFFFFFF then 0x00000000. rdy low for 3 cycles mid-load -> mem_a_o frozen; result and cycle count otherwise unchanged.
- Assert rst during the second READ cycle -> next cycle stall_req_o 0, rd_o/we_o/wdata_o 0, mem_wr_o 0; a following LW completes correctly.
